// File: rtl/seg_display.sv
// Eight-digit multiplexed hex display driver for common-anode seven-segment displays.
// The displayed word is snapshotted once per frame so digits never change mid-frame.
module seg_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic        blank_lz,
    output logic [7:0]  led_en,
    output logic [7:0]  led_seg
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          shadow_lz_q, shadow_lz_d;
    logic          fresh_q, fresh_d;
    logic [7:0]    led_en_q, led_en_d;
    logic [7:0]    led_seg_q, led_seg_d;

    logic          last_slot_s;
    logic [31:0]   upper_s;
    logic          blank_s;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}, decimal point always off
    function automatic logic [7:0] decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Scan counter, digit index and once-per-frame snapshot
    always_comb begin
        last_slot_s = (cnt_q == CNT_MAX);
        if (last_slot_s) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end
        if (fresh_q || (last_slot_s && (idx_q == 3'd7))) begin
            shadow_d    = data;
            shadow_lz_d = blank_lz;
        end else begin
            shadow_d    = shadow_q;
            shadow_lz_d = shadow_lz_q;
        end
        fresh_d = 1'b0;
    end

    // Pin values for the current slot; cnt==0 is the dead-time cycle between digits
    always_comb begin
        upper_s = shadow_q >> {idx_q, 2'b00};
        blank_s = shadow_lz_q && (idx_q != 3'd0) && (upper_s == 32'd0);
        if (cnt_q == '0) begin
            led_en_d  = 8'hFF;
            led_seg_d = 8'hFF;
        end else begin
            led_en_d = ~(8'h01 << idx_q);
            if (blank_s) begin
                led_seg_d = 8'hFF;
            end else begin
                led_seg_d = decode(upper_s[3:0]);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shadow_q    <= 32'd0;
            shadow_lz_q <= 1'b0;
            fresh_q     <= 1'b1;
            led_en_q    <= 8'hFF;
            led_seg_q   <= 8'hFF;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_lz_q <= shadow_lz_d;
            fresh_q     <= fresh_d;
            led_en_q    <= led_en_d;
            led_seg_q   <= led_seg_d;
        end
    end

    assign led_en  = led_en_q;
    assign led_seg = led_seg_q;

endmodule

// File: tb/tb_seg_display.sv
// Testbench for seg_display with SCAN_DIV=4, checked against a frame-level reference model.
module tb_seg_display;

    localparam int SD = 4;
    localparam int FRAME = 8 * SD;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        blank_lz;
    logic [7:0]  led_en;
    logic [7:0]  led_seg;

    int total;
    int bad;

    // Reference model: cycles since release, current snapshot
    int          p;
    logic [31:0] snap;
    logic        snap_lz;
    logic        fresh;
    logic [7:0]  exp_en;
    logic [7:0]  exp_seg;
    logic [7:0]  seg_tab [16];

    seg_display #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .blank_lz(blank_lz),
        .led_en  (led_en),
        .led_seg (led_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        p       = 0;
        snap    = 32'd0;
        snap_lz = 1'b0;
        fresh   = 1'b1;
    endtask

    // One clock edge: expected pins come from the position in the frame and the snapshot
    task automatic tick();
        int          c;
        int          d;
        logic [31:0] up;
        @(posedge clk);
        c  = p % SD;
        d  = (p / SD) % 8;
        up = snap >> (4 * d);
        if (c == 0) begin
            exp_en  = 8'hFF;
            exp_seg = 8'hFF;
        end else begin
            exp_en = ~(8'h01 << d);
            if (snap_lz && d != 0 && up == 32'd0) exp_seg = 8'hFF;
            else exp_seg = seg_tab[up[3:0]];
        end
        if (fresh || (c == SD - 1 && d == 7)) begin
            snap    = data;
            snap_lz = blank_lz;
            fresh   = 1'b0;
        end
        p = p + 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        data     = 32'h12345678;
        blank_lz = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (led_en !== 8'hFF || led_seg !== 8'hFF) begin
            bad++;
            $display("FAIL reset_hold: en=%h seg=%h want FF/FF", led_en, led_seg);
        end
    endtask

    task automatic test_first_frame();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL first_frame k=%0d: en=%h seg=%h want %h/%h", k, led_en, led_seg, exp_en, exp_seg);
            end
            if (k == 1 || k == 2 || k == 6) begin
                total++;
                if ((k == 1 && (led_en !== 8'hFF || led_seg !== 8'hFF)) ||
                    (k == 2 && (led_en !== 8'hFE || led_seg !== 8'h80)) ||
                    (k == 6 && (led_en !== 8'hFD || led_seg !== 8'hF8))) begin
                    bad++;
                    $display("FAIL first_frame_fixed k=%0d: en=%h seg=%h", k, led_en, led_seg);
                end
            end
        end
    endtask

    task automatic test_frame_consistency();
        data = 32'hFFFFFFFF;
        for (int k = 11; k <= 40; k++) begin
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL consistency k=%0d: en=%h seg=%h want %h/%h", k, led_en, led_seg, exp_en, exp_seg);
            end
            if (k == 30 || k == 34) begin
                total++;
                if ((k == 30 && (led_en !== 8'h7F || led_seg !== 8'hF9)) ||
                    (k == 34 && (led_en !== 8'hFE || led_seg !== 8'h8E))) begin
                    bad++;
                    $display("FAIL consistency_fixed k=%0d: en=%h seg=%h", k, led_en, led_seg);
                end
            end
        end
    endtask

    task automatic test_blanking();
        data     = 32'h000000A0;
        blank_lz = 1'b1;
        do begin
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL blank_align: en=%h seg=%h want %h/%h", led_en, led_seg, exp_en, exp_seg);
            end
        end while (p % FRAME != 0);
        repeat (FRAME) begin
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL blank_a0: en=%h seg=%h want %h/%h", led_en, led_seg, exp_en, exp_seg);
            end
            if ((p - 1) % FRAME == 1 || (p - 1) % FRAME == 5 || (p - 1) % FRAME == 21) begin
                total++;
                if (((p - 1) % FRAME == 1  && (led_en !== 8'hFE || led_seg !== 8'hC0)) ||
                    ((p - 1) % FRAME == 5  && (led_en !== 8'hFD || led_seg !== 8'h88)) ||
                    ((p - 1) % FRAME == 21 && (led_en !== 8'hDF || led_seg !== 8'hFF))) begin
                    bad++;
                    $display("FAIL blank_a0_fixed pos=%0d: en=%h seg=%h", (p - 1) % FRAME, led_en, led_seg);
                end
            end
        end
        data = 32'd0;
        do begin
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL blank_zero: en=%h seg=%h want %h/%h", led_en, led_seg, exp_en, exp_seg);
            end
        end while (p % FRAME != 0);
        repeat (FRAME) begin
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL blank_zero: en=%h seg=%h want %h/%h", led_en, led_seg, exp_en, exp_seg);
            end
            if ((p - 1) % FRAME == 1 || (p - 1) % FRAME == 13) begin
                total++;
                if (((p - 1) % FRAME == 1  && led_seg !== 8'hC0) ||
                    ((p - 1) % FRAME == 13 && (led_en !== 8'hF7 || led_seg !== 8'hFF))) begin
                    bad++;
                    $display("FAIL blank_zero_fixed pos=%0d: en=%h seg=%h", (p - 1) % FRAME, led_en, led_seg);
                end
            end
        end
    endtask

    task automatic test_decode_sweep();
        logic [31:0] words [2];
        words[0] = 32'hFEDCBA98;
        words[1] = 32'h76543210;
        blank_lz = 1'b0;
        for (int w = 0; w < 2; w++) begin
            data = words[w];
            do begin
                tick();
                total++;
                if (led_en !== exp_en || led_seg !== exp_seg) begin
                    bad++;
                    $display("FAIL sweep w=%0d: en=%h seg=%h want %h/%h", w, led_en, led_seg, exp_en, exp_seg);
                end
            end while (p % FRAME != 0);
        end
        repeat (FRAME) begin
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL sweep_last: en=%h seg=%h want %h/%h", led_en, led_seg, exp_en, exp_seg);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6 * FRAME; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                data     = $urandom >> $urandom_range(0, 31);
                blank_lz = 1'($urandom_range(0, 1));
            end
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL random k=%0d data=%h: en=%h seg=%h want %h/%h", k, snap, led_en, led_seg, exp_en, exp_seg);
            end
        end
    endtask

    task automatic test_mid_reset();
        data     = 32'h89ABCDEF;
        blank_lz = 1'b0;
        do begin
            tick();
        end while (p % FRAME != 23);
        total++;
        if (led_en !== 8'hDF || led_seg !== exp_seg) begin
            bad++;
            $display("FAIL pre_reset_digit5: en=%h seg=%h want DF/%h", led_en, led_seg, exp_seg);
        end
        #2;
        rst_n = 1'b0;
        data  = 32'hCAFE0123;
        #1;
        total++;
        if (led_en !== 8'hFF || led_seg !== 8'hFF) begin
            bad++;
            $display("FAIL async_reset: en=%h seg=%h want FF/FF", led_en, led_seg);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (led_en !== 8'hFF || led_seg !== 8'hFF) begin
            bad++;
            $display("FAIL reset_held: en=%h seg=%h want FF/FF", led_en, led_seg);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= FRAME + 4; k++) begin
            tick();
            total++;
            if (led_en !== exp_en || led_seg !== exp_seg) begin
                bad++;
                $display("FAIL after_reset k=%0d: en=%h seg=%h want %h/%h", k, led_en, led_seg, exp_en, exp_seg);
            end
            if (k == 2) begin
                total++;
                if (led_en !== 8'hFE || led_seg !== 8'hB0) begin
                    bad++;
                    $display("FAIL restart_digit0: en=%h seg=%h want FE/B0", led_en, led_seg);
                end
            end
        end
    endtask

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        total = 0;
        bad   = 0;
        test_reset();
        test_first_frame();
        test_frame_consistency();
        test_blanking();
        test_decode_sweep();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
